// File: rtl/nibble_load_driver.sv
// Host-side initiator: loads two 8-bit operands into the nibble-load engine, waits, returns product.
// Optional echo checking of the load bus is enabled by defining ECHO_CHECK_EN.
module nibble_load_driver #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          WEIGHT_FIRST  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       op_valid_i,
   output logic       op_ready_o,
   input  logic [7:0] in_op_i,
   input  logic [7:0] wt_op_i,
   output logic [7:0] bus_o,
   input  logic [7:0] bus_i,
   output logic       res_valid_o,
   input  logic       res_ready_i,
   output logic [7:0] res_o,
`ifdef ECHO_CHECK_EN
   output logic       echo_err_o,
`endif
   output logic       busy_o
);

   typedef enum logic [2:0] {StIdle, StLd0, StLd1, StLd2, StLd3, StCmp, StRes} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] in_q, in_d, wt_q, wt_d;
   logic [7:0] bus_q, bus_d;
   logic [7:0] res_q, res_d;
   logic       res_valid_q, res_valid_d;
   logic [7:0] ld_in, ld_wt;

   function automatic logic [7:0] ld_word(logic is_in, logic lsb, logic [7:0] a, logic [7:0] w);
      logic [7:0] op;
      op = is_in ? a : w;
      return {1'b1, lsb, is_in, 1'b0, (lsb ? op[3:0] : op[7:4])};
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_d        = in_q;
      wt_d        = wt_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      ld_in       = in_q;
      ld_wt       = wt_q;
      bus_d       = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (op_valid_i) begin
               state_d = StLd0;
               in_d    = in_op_i;
               wt_d    = wt_op_i;
               // The first load word must come from the operands being accepted now
               ld_in   = in_op_i;
               ld_wt   = wt_op_i;
            end
         end
         StLd0: state_d = StLd1;
         StLd1: state_d = StLd2;
         StLd2: state_d = StLd3;
         StLd3: begin
            state_d = StCmp;
            cnt_d   = 4'd0;
         end
         StCmp: begin
            if (cnt_q == SettleLast) begin
               state_d     = StRes;
               cnt_d       = 4'd0;
               res_d       = bus_i;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StRes: begin
            if (res_ready_i) begin
               state_d     = StIdle;
               res_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Bus word is registered on entry to each load state
      unique case (state_d)
         StLd0:   bus_d = ld_word(!WEIGHT_FIRST, 1'b1, ld_in, ld_wt);
         StLd1:   bus_d = ld_word(!WEIGHT_FIRST, 1'b0, ld_in, ld_wt);
         StLd2:   bus_d = ld_word(WEIGHT_FIRST, 1'b1, ld_in, ld_wt);
         StLd3:   bus_d = ld_word(WEIGHT_FIRST, 1'b0, ld_in, ld_wt);
         default: bus_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         in_q        <= 8'h00;
         wt_q        <= 8'h00;
         bus_q       <= 8'h00;
         res_q       <= 8'h00;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_q        <= in_d;
         wt_q        <= wt_d;
         bus_q       <= bus_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus_o       = bus_q;
   assign res_o       = res_q;
   assign res_valid_o = res_valid_q;
   assign op_ready_o  = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);

`ifdef ECHO_CHECK_EN
   logic err_q, err_d;
   logic in_load;

   assign in_load = (state_q == StLd0) || (state_q == StLd1) ||
                    (state_q == StLd2) || (state_q == StLd3);

   always_comb begin
      err_d = err_q;
      if ((state_q == StIdle) && op_valid_i) begin
         err_d = 1'b0;
      end else if (in_load && (bus_i != bus_q)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign echo_err_o = err_q;
`endif

endmodule

// File: tb/tb_nibble_load_driver.sv
// Directed bench: two driver instances (default and WEIGHT_FIRST=1/SETTLE_CYCLES=3) with engine models.
module tb_nibble_load_driver;

   logic       clk;
   logic       rst_n;
   logic       op_valid;
   logic [7:0] in_op, wt_op;
   logic       res_ready;

   logic       op_ready_a, res_valid_a, busy_a;
   logic [7:0] bus_a, bus_in_a, res_a;
   logic       op_ready_b, res_valid_b, busy_b;
   logic [7:0] bus_b, bus_in_b, res_b;
`ifdef ECHO_CHECK_EN
   logic       echo_err_a, echo_err_b;
`endif
   logic       kill_a;

   int total = 0;
   int bad   = 0;

   nibble_load_driver dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .op_valid_i  (op_valid),
      .op_ready_o  (op_ready_a),
      .in_op_i     (in_op),
      .wt_op_i     (wt_op),
      .bus_o       (bus_a),
      .bus_i       (bus_in_a),
      .res_valid_o (res_valid_a),
      .res_ready_i (res_ready),
      .res_o       (res_a),
`ifdef ECHO_CHECK_EN
      .echo_err_o  (echo_err_a),
`endif
      .busy_o      (busy_a)
   );

   nibble_load_driver #(.SETTLE_CYCLES(3), .WEIGHT_FIRST(1'b1)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .op_valid_i  (op_valid),
      .op_ready_o  (op_ready_b),
      .in_op_i     (in_op),
      .wt_op_i     (wt_op),
      .bus_o       (bus_b),
      .bus_i       (bus_in_b),
      .res_valid_o (res_valid_b),
      .res_ready_i (res_ready),
      .res_o       (res_b),
`ifdef ECHO_CHECK_EN
      .echo_err_o  (echo_err_b),
`endif
      .busy_o      (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine models: capture nibbles from the load bus, echo in load mode, product otherwise
   logic [7:0]  ein_a, ewt_a, ein_b, ewt_b;
   logic [15:0] prod_a, prod_b;
   assign prod_a   = ein_a * ewt_a;
   assign prod_b   = ein_b * ewt_b;
   assign bus_in_a = bus_a[7] ? (bus_a & ~{5'b0, kill_a, 2'b0}) : prod_a[7:0];
   assign bus_in_b = bus_b[7] ? bus_b : prod_b[7:0];

   always @(posedge clk) begin
      if (!rst_n) begin
         ein_a <= 8'h00; ewt_a <= 8'h00; ein_b <= 8'h00; ewt_b <= 8'h00;
      end else begin
         if (bus_a[7]) begin
            case (bus_a[6:5])
               2'b11: ein_a[3:0] <= bus_a[3:0];
               2'b01: ein_a[7:4] <= bus_a[3:0];
               2'b10: ewt_a[3:0] <= bus_a[3:0];
               default: ewt_a[7:4] <= bus_a[3:0];
            endcase
         end
         if (bus_b[7]) begin
            case (bus_b[6:5])
               2'b11: ein_b[3:0] <= bus_b[3:0];
               2'b01: ein_b[7:4] <= bus_b[3:0];
               2'b10: ewt_b[3:0] <= bus_b[3:0];
               default: ewt_b[7:4] <= bus_b[3:0];
            endcase
         end
      end
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on both instances; seq_* hold the expected load words
   task automatic do_op(input logic [7:0] a, input logic [7:0] w, input logic [7:0] exp,
                        input int hold, input logic kill);
      logic [7:0] seq_a [4];
      logic [7:0] seq_b [4];
      seq_a[0] = {4'b1110, a[3:0]};
      seq_a[1] = {4'b1010, a[7:4]};
      seq_a[2] = {4'b1100, w[3:0]};
      seq_a[3] = {4'b1000, w[7:4]};
      seq_b[0] = seq_a[2];
      seq_b[1] = seq_a[3];
      seq_b[2] = seq_a[0];
      seq_b[3] = seq_a[1];
      op_valid = 1'b1; in_op = a; wt_op = w;
      tick();
      op_valid = 1'b0;
      check_eq("op_ready_a_busy", op_ready_a, 1'b0);
      check_eq("busy_b", busy_b, 1'b1);
`ifdef ECHO_CHECK_EN
      check_eq("echo_clear_a", echo_err_a, 1'b0);
`endif
      for (int i = 0; i < 4; i++) begin
         kill_a = kill && (i == 1);
         check_eq($sformatf("bus_a_ld%0d", i), bus_a, seq_a[i]);
         check_eq($sformatf("bus_b_ld%0d", i), bus_b, seq_b[i]);
         tick();
         kill_a = 1'b0;
      end
      check_eq("bus_a_cmp", bus_a, 8'h00);
      check_eq("res_valid_a_c5", res_valid_a, 1'b0);
      tick();
      check_eq("res_valid_a_c6", res_valid_a, 1'b1);
      check_eq("res_a", res_a, exp);
      tick();
      check_eq("res_valid_b_c7", res_valid_b, 1'b0);
      tick();
      check_eq("res_valid_b_c8", res_valid_b, 1'b1);
      check_eq("res_b", res_b, exp);
      for (int i = 0; i < hold; i++) begin
         op_valid = 1'b1; in_op = 8'h55; wt_op = 8'h0F;
         tick();
         check_eq("hold_res_valid_a", res_valid_a, 1'b1);
         check_eq("hold_res_a", res_a, exp);
         check_eq("hold_op_ready_a", op_ready_a, 1'b0);
         check_eq("hold_res_b", res_b, exp);
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_eq("post_res_valid_a", res_valid_a, 1'b0);
      check_eq("post_res_valid_b", res_valid_b, 1'b0);
      check_eq("post_op_ready_a", op_ready_a, 1'b1);
      check_eq("post_op_ready_b", op_ready_b, 1'b1);
      check_eq("post_res_a_kept", res_a, exp);
`ifdef ECHO_CHECK_EN
      check_eq("echo_err_a", echo_err_a, kill);
      check_eq("echo_err_b", echo_err_b, 1'b0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; op_valid = 1'b0; in_op = 8'h00; wt_op = 8'h00;
      res_ready = 1'b0; kill_a = 1'b0;
      tick();
      tick();
      check_eq("rst_bus", bus_a, 8'h00);
      check_eq("rst_op_ready", op_ready_a, 1'b1);
      check_eq("rst_res_valid", res_valid_a, 1'b0);
      check_eq("rst_res", res_a, 8'h00);
      check_eq("rst_busy", busy_a, 1'b0);
`ifdef ECHO_CHECK_EN
      check_eq("rst_echo", echo_err_a, 1'b0);
`endif
      rst_n = 1'b1;
      tick();

      // Literal check of the default load sequence for in=0x12, wt=0x03
      op_valid = 1'b1; in_op = 8'h12; wt_op = 8'h03;
      tick();
      op_valid = 1'b0;
      check_eq("lit_e2", bus_a, 8'hE2);
      check_eq("lit_b_c3", bus_b, 8'hC3);
      tick();
      check_eq("lit_a1", bus_a, 8'hA1);
      check_eq("lit_b_80", bus_b, 8'h80);
      tick();
      check_eq("lit_c3", bus_a, 8'hC3);
      check_eq("lit_b_e2", bus_b, 8'hE2);
      tick();
      check_eq("lit_80", bus_a, 8'h80);
      check_eq("lit_b_a1", bus_b, 8'hA1);
      tick();
      check_eq("lit_00", bus_a, 8'h00);
      tick();
      check_eq("lit_res_valid", res_valid_a, 1'b1);
      check_eq("lit_res", res_a, 8'h36);
      tick();
      tick();
      check_eq("lit_res_b", res_b, 8'h36);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      do_op(8'h12, 8'h03, 8'h36, 0, 1'b0);
      do_op(8'hFF, 8'hFF, 8'h01, 0, 1'b0);
      do_op(8'h00, 8'hA5, 8'h00, 10, 1'b0);

      // Reset during LD2 of both instances' load phase
      op_valid = 1'b1; in_op = 8'h33; wt_op = 8'h44;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("mid_rst_bus", bus_a, 8'h00);
      check_eq("mid_rst_op_ready", op_ready_a, 1'b1);
      check_eq("mid_rst_res_valid", res_valid_a, 1'b0);
      check_eq("mid_rst_bus_b", bus_b, 8'h00);
      do_op(8'h07, 8'h06, 8'h2A, 0, 1'b0);

`ifdef ECHO_CHECK_EN
      do_op(8'h47, 8'h03, 8'hD5, 0, 1'b1);
      do_op(8'h02, 8'h05, 8'h0A, 0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
